mem_sequencer: RTL and testbench



---
 rtl/mem_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_mem_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - run controller: load INS/DATA RAMs, start processor, stream results out
module mem_sequencer #(
    parameter int INS_WIDTH           = 8,
    parameter int DATA_MEM_WIDTH      = 12,
    parameter int INS_MEM_ADDR_WIDTH  = 8,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int INS_LEN             = 256,
    parameter int DATA_LEN            = 4096,
    parameter int RESULT_BASE         = 0,
    parameter int RESULT_LEN          = 4096,
    parameter int PROC_TIMEOUT        = 2**20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_MEM_WIDTH-1:0]      in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_MEM_WIDTH-1:0]      out_data,
    output logic                           proc_start,
    input  logic                           proc_ready,
    input  logic                           proc_done,
    input  logic [INS_MEM_ADDR_WIDTH-1:0]  proc_ins_addr,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0] proc_data_addr,
    input  logic [DATA_MEM_WIDTH-1:0]      proc_data_out,
    input  logic                           proc_data_wr_en,
    output logic [INS_MEM_ADDR_WIDTH-1:0]  ins_mem_addr,
    output logic                           ins_mem_wr_en,
    output logic [INS_WIDTH-1:0]           ins_mem_din,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] data_mem_addr,
    output logic                           data_mem_wr_en,
    output logic [DATA_MEM_WIDTH-1:0]      data_mem_din,
    input  logic [DATA_MEM_WIDTH-1:0]      data_mem_dout,
    output logic [3:0]                     state,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout_err
);

    localparam int CNT_W = ((INS_MEM_ADDR_WIDTH > DATA_MEM_ADDR_WIDTH) ?
                            INS_MEM_ADDR_WIDTH : DATA_MEM_ADDR_WIDTH) + 1;
    localparam int TO_W  = $clog2(PROC_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD_INS   = 4'd1,
        S_LOAD_DATA  = 4'd2,
        S_WAIT_READY = 4'd3,
        S_PROCESS    = 4'd4,
        S_DUMP_RD    = 4'd5,
        S_DUMP_WAIT  = 4'd6,
        S_DUMP_SEND  = 4'd7,
        S_FINISH     = 4'd8
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [TO_W-1:0]           r_tcnt;
    logic [DATA_MEM_WIDTH-1:0] r_out_data;
    logic                      r_timeout_err;

    logic                           w_load;
    logic                           w_accept;
    logic [DATA_MEM_ADDR_WIDTH-1:0] w_dump_addr;

    assign w_load      = (r_state == S_LOAD_INS) || (r_state == S_LOAD_DATA);
    assign w_accept    = w_load && in_valid;
    assign w_dump_addr = DATA_MEM_ADDR_WIDTH'(RESULT_BASE) + r_cnt[DATA_MEM_ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_tcnt        <= '0;
            r_out_data    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        r_state       <= S_LOAD_INS;
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_LOAD_INS: begin
                    if (w_accept) begin
                        if (r_cnt == CNT_W'(INS_LEN - 1)) begin
                            r_state <= S_LOAD_DATA;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_DATA: begin
                    if (w_accept) begin
                        if (r_cnt == CNT_W'(DATA_LEN - 1)) begin
                            r_state <= S_WAIT_READY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT_READY: begin
                    if (proc_ready) begin
                        r_state <= S_PROCESS;
                        r_tcnt  <= '0;
                    end
                end
                S_PROCESS: begin
                    // proc_done wins over a timeout landing on the same cycle
                    if (proc_done) begin
                        r_state <= S_DUMP_RD;
                        r_cnt   <= '0;
                    end else if (r_tcnt == TO_W'(PROC_TIMEOUT - 1)) begin
                        r_state       <= S_FINISH;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DUMP_RD:   r_state <= S_DUMP_WAIT;
                S_DUMP_WAIT: begin
                    r_out_data <= data_mem_dout;
                    r_state    <= S_DUMP_SEND;
                end
                S_DUMP_SEND: begin
                    if (out_ready) begin
                        if (r_cnt == CNT_W'(RESULT_LEN - 1)) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_DUMP_RD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready       = w_load;
        out_valid      = (r_state == S_DUMP_SEND);
        proc_start     = (r_state == S_WAIT_READY) && proc_ready;
        ins_mem_addr   = '0;
        ins_mem_wr_en  = 1'b0;
        ins_mem_din    = '0;
        data_mem_addr  = '0;
        data_mem_wr_en = 1'b0;
        data_mem_din   = '0;
        case (r_state)
            S_LOAD_INS: begin
                if (w_accept) begin
                    ins_mem_wr_en = 1'b1;
                    ins_mem_addr  = r_cnt[INS_MEM_ADDR_WIDTH-1:0];
                    ins_mem_din   = in_data[INS_WIDTH-1:0];
                end
            end
            S_LOAD_DATA: begin
                if (w_accept) begin
                    data_mem_wr_en = 1'b1;
                    data_mem_addr  = r_cnt[DATA_MEM_ADDR_WIDTH-1:0];
                    data_mem_din   = in_data;
                end
            end
            S_PROCESS: begin
                ins_mem_addr   = proc_ins_addr;
                data_mem_addr  = proc_data_addr;
                data_mem_din   = proc_data_out;
                data_mem_wr_en = proc_data_wr_en;
            end
            S_DUMP_RD, S_DUMP_WAIT: data_mem_addr = w_dump_addr;
            default: ;
        endcase
    end

    assign out_data    = r_out_data;
    assign state       = r_state;
    assign busy        = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done        = (r_state == S_FINISH);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - directed bench for mem_sequencer with behavioural INS/DATA RAMs
module tb_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        proc_start;
    logic        proc_ready;
    logic        proc_done;
    logic [7:0]  proc_ins_addr;
    logic [11:0] proc_data_addr;
    logic [11:0] proc_data_out;
    logic        proc_data_wr_en;
    logic [7:0]  ins_mem_addr;
    logic        ins_mem_wr_en;
    logic [7:0]  ins_mem_din;
    logic [11:0] data_mem_addr;
    logic        data_mem_wr_en;
    logic [11:0] data_mem_din;
    logic [11:0] data_mem_dout;
    logic [3:0]  state;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  ins_ram  [256];
    logic [11:0] data_ram [4096];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ins_mem_wr_en)  ins_ram[ins_mem_addr]   <= ins_mem_din;
        if (data_mem_wr_en) data_ram[data_mem_addr] <= data_mem_din;
        data_mem_dout <= data_ram[data_mem_addr];
    end

    mem_sequencer #(
        .INS_WIDTH(8), .DATA_MEM_WIDTH(12), .INS_MEM_ADDR_WIDTH(8), .DATA_MEM_ADDR_WIDTH(12),
        .INS_LEN(4), .DATA_LEN(3), .RESULT_BASE(10), .RESULT_LEN(2), .PROC_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .proc_start(proc_start), .proc_ready(proc_ready), .proc_done(proc_done),
        .proc_ins_addr(proc_ins_addr), .proc_data_addr(proc_data_addr),
        .proc_data_out(proc_data_out), .proc_data_wr_en(proc_data_wr_en),
        .ins_mem_addr(ins_mem_addr), .ins_mem_wr_en(ins_mem_wr_en), .ins_mem_din(ins_mem_din),
        .data_mem_addr(data_mem_addr), .data_mem_wr_en(data_mem_wr_en),
        .data_mem_din(data_mem_din), .data_mem_dout(data_mem_dout),
        .state(state), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    // Pulses start and offers n consecutive words; returns once the last word is presented.
    task automatic load_words(input logic [11:0] base, input int n, output int accepted);
        int guard;
        accepted = 0;
        guard    = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (accepted < n && guard < 100) begin
            if (guard > 0) @(negedge clk);
            in_valid = 1'b1;
            in_data  = base + 12'(accepted);
            #1;
            if (in_ready) accepted++;
            guard++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (state !== 4'd0)       begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_cmp++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 12'h0)   begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_cmp++; if ({busy, done, timeout_err, proc_start} !== 4'b0)
            begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, timeout_err, proc_start}); end
        n_cmp++; if ({ins_mem_wr_en, data_mem_wr_en} !== 2'b0 || ins_mem_addr !== 8'h0 || data_mem_addr !== 12'h0)
            begin n_err++; $display("FAIL reset_mem_ports got=%b/%h/%h exp=0", {ins_mem_wr_en, data_mem_wr_en}, ins_mem_addr, data_mem_addr); end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (state !== 4'd0 || busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got=%0d exp=0", state); end
    endtask

    task automatic test_load;
        int acc;
        load_words(12'h0A1, 7, acc);
        n_cmp++; if (acc !== 7) begin n_err++; $display("FAIL load_accepts got=%0d exp=7", acc); end
        @(negedge clk); in_data = 12'hFFF; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL load_in_ready_drop got=%b exp=0", in_ready); end
        n_cmp++; if (state !== 4'd3)    begin n_err++; $display("FAIL load_state got=%0d exp=3", state); end
        n_cmp++; if (data_mem_wr_en !== 1'b0 || ins_mem_wr_en !== 1'b0)
            begin n_err++; $display("FAIL load_no_write_after got=%b%b exp=00", ins_mem_wr_en, data_mem_wr_en); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ins_ram[i] !== 8'(8'hA1 + i))
                begin n_err++; $display("FAIL load_ins_ram[%0d] got=%h exp=%h", i, ins_ram[i], 8'(8'hA1 + i)); end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (data_ram[i] !== 12'(12'h0A5 + i))
                begin n_err++; $display("FAIL load_data_ram[%0d] got=%h exp=%h", i, data_ram[i], 12'(12'h0A5 + i)); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_wait_ready;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (proc_start !== 1'b0 || state !== 4'd3)
                begin n_err++; $display("FAIL wait_hold[%0d] got=start%b/st%0d exp=start0/st3", i, proc_start, state); end
        end
        @(negedge clk); proc_ready = 1'b1; #1;
        n_cmp++; if (proc_start !== 1'b1 || state !== 4'd3)
            begin n_err++; $display("FAIL wait_start_pulse got=start%b/st%0d exp=start1/st3", proc_start, state); end
        @(negedge clk); proc_ready = 1'b0; #1;
        n_cmp++; if (proc_start !== 1'b0 || state !== 4'd4)
            begin n_err++; $display("FAIL wait_enter_process got=start%b/st%0d exp=start0/st4", proc_start, state); end
    endtask

    task automatic test_process;
        @(negedge clk);
        proc_ins_addr = 8'h05; proc_data_addr = 12'd10; proc_data_out = 12'h123; proc_data_wr_en = 1'b1;
        #1;
        n_cmp++; if (data_mem_wr_en !== 1'b1 || data_mem_addr !== 12'd10 || data_mem_din !== 12'h123)
            begin n_err++; $display("FAIL proc_pass_wr got=%b/%h/%h exp=1/00a/123", data_mem_wr_en, data_mem_addr, data_mem_din); end
        n_cmp++; if (ins_mem_addr !== 8'h05 || ins_mem_wr_en !== 1'b0)
            begin n_err++; $display("FAIL proc_pass_ins got=%h/%b exp=05/0", ins_mem_addr, ins_mem_wr_en); end
        @(negedge clk);
        proc_data_addr = 12'd11; proc_data_out = 12'h456; proc_done = 1'b1;
        #1;
        n_cmp++; if (data_mem_wr_en !== 1'b1 || data_mem_addr !== 12'd11 || data_mem_din !== 12'h456)
            begin n_err++; $display("FAIL proc_done_wr got=%b/%h/%h exp=1/00b/456", data_mem_wr_en, data_mem_addr, data_mem_din); end
        @(negedge clk);
        proc_done = 1'b0; proc_data_wr_en = 1'b0; proc_data_addr = 12'd0; proc_ins_addr = 8'd0;
        #1;
        n_cmp++; if (state !== 4'd5 || data_mem_addr !== 12'd10 || data_mem_wr_en !== 1'b0)
            begin n_err++; $display("FAIL dump_rd_addr got=st%0d/%h/%b exp=st5/00a/0", state, data_mem_addr, data_mem_wr_en); end
        n_cmp++; if (data_ram[10] !== 12'h123 || data_ram[11] !== 12'h456)
            begin n_err++; $display("FAIL proc_ram_written got=%h/%h exp=123/456", data_ram[10], data_ram[11]); end
    endtask

    task automatic test_dump_backpressure;
        logic [11:0] exp_w [2];
        int received;
        int hold;
        int guard;
        exp_w[0] = 12'h123; exp_w[1] = 12'h456;
        received = 0; hold = 0; guard = 0;
        while (received < 2 && guard < 60) begin
            @(negedge clk); out_ready = 1'b0; #1;
            if (out_valid) begin
                if (received == 1 && hold < 4) begin
                    hold++;
                    n_cmp++; if (out_data !== exp_w[1])
                        begin n_err++; $display("FAIL dump_stall_stable[%0d] got=%h exp=%h", hold, out_data, exp_w[1]); end
                end else begin
                    n_cmp++; if (out_data !== exp_w[received])
                        begin n_err++; $display("FAIL dump_word[%0d] got=%h exp=%h", received, out_data, exp_w[received]); end
                    out_ready = 1'b1;
                    received++;
                end
            end
            guard++;
        end
        n_cmp++; if (received !== 2 || hold !== 4)
            begin n_err++; $display("FAIL dump_count got=%0d/hold%0d exp=2/hold4", received, hold); end
        @(negedge clk); out_ready = 1'b0; #1;
        n_cmp++; if (state !== 4'd8 || done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL dump_finish got=st%0d/d%b/b%b/v%b exp=st8/d1/b0/v0", state, done, busy, out_valid); end
        n_cmp++; if (timeout_err !== 1'b0 || out_data !== 12'h456)
            begin n_err++; $display("FAIL finish_hold got=te%b/%h exp=te0/456", timeout_err, out_data); end
    endtask

    task automatic test_timeout;
        int acc;
        int pcycles;
        int guard;
        logic saw_valid;
        load_words(12'h0B1, 7, acc);
        proc_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        pcycles = 0; guard = 0; saw_valid = 1'b0;
        while (state !== 4'd8 && guard < 40) begin
            @(negedge clk); #1;
            if (state === 4'd4) pcycles++;
            if (out_valid) saw_valid = 1'b1;
            guard++;
        end
        proc_ready = 1'b0;
        n_cmp++; if (pcycles !== 8) begin n_err++; $display("FAIL timeout_cycles got=%0d exp=8", pcycles); end
        n_cmp++; if (timeout_err !== 1'b1 || done !== 1'b1)
            begin n_err++; $display("FAIL timeout_flags got=te%b/d%b exp=te1/d1", timeout_err, done); end
        n_cmp++; if (saw_valid !== 1'b0) begin n_err++; $display("FAIL timeout_no_dump got=%b exp=0", saw_valid); end
    endtask

    task automatic test_reset_mid_run;
        int acc;
        load_words(12'h0C1, 5, acc);
        @(negedge clk);
        n_cmp++; if (state !== 4'd2) begin n_err++; $display("FAIL midrst_pre_state got=%0d exp=2", state); end
        rst = 1'b1; #1;
        n_cmp++; if (state !== 4'd0 || in_ready !== 1'b0 || ins_mem_wr_en !== 1'b0 || data_mem_wr_en !== 1'b0)
            begin n_err++; $display("FAIL midrst_abort got=st%0d/r%b/%b%b exp=st0/r0/00", state, in_ready, ins_mem_wr_en, data_mem_wr_en); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL midrst_te got=%b exp=0", timeout_err); end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        load_words(12'h0D1, 7, acc);
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++; if (state !== 4'd3) begin n_err++; $display("FAIL reload_state got=%0d exp=3", state); end
        n_cmp++; if (ins_ram[0] !== 8'hD1 || ins_ram[3] !== 8'hD4)
            begin n_err++; $display("FAIL reload_ins got=%h/%h exp=d1/d4", ins_ram[0], ins_ram[3]); end
        n_cmp++; if (data_ram[0] !== 12'h0D5 || data_ram[2] !== 12'h0D7)
            begin n_err++; $display("FAIL reload_data got=%h/%h exp=0d5/0d7", data_ram[0], data_ram[2]); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        proc_ready = 1'b0; proc_done = 1'b0; proc_ins_addr = '0; proc_data_addr = '0;
        proc_data_out = '0; proc_data_wr_en = 1'b0;
        test_reset();
        test_load();
        test_wait_ready();
        test_process();
        test_dump_backpressure();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
